// File: rtl/bumpy_motion_fsm.sv
`default_nettype none
// ============================================================================
// Module  : bumpy_motion_fsm
// Brief   : Player-ball motion sequencer producing per-frame X/Y speed commands
// Rev     : 1.0
// ============================================================================
module bumpy_motion_fsm #(
  parameter int SIDE_SPEED  = 160,
  parameter int SIDE_FRAMES = 16,
  parameter int JUMP_SPEED  = -320,
  parameter int GRAVITY     = 16,
  parameter int MAX_FALL    = 512
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               right,
  input  logic               left,
  input  logic               jump,
  input  logic               collision,
  input  logic [3:0]         HitEdgeCode,
  output logic signed [15:0] Xspeed,
  output logic signed [15:0] Yspeed,
  output logic [1:0]         state,
  output logic               onGround
);

  localparam int                 CNT_W         = $clog2(SIDE_FRAMES + 1);
  localparam logic signed [15:0] c_SIDE_SPEED  = 16'(SIDE_SPEED);
  localparam logic signed [15:0] c_JUMP_SPEED  = 16'(JUMP_SPEED);
  localparam logic signed [15:0] c_GRAVITY     = 16'(GRAVITY);
  localparam logic signed [15:0] c_MAX_FALL    = 16'(MAX_FALL);
  localparam logic [CNT_W-1:0]   c_SIDE_FRAMES = CNT_W'(SIDE_FRAMES);
  localparam logic [CNT_W-1:0]   c_CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    S_GROUND = 2'd0,
    S_SIDE   = 2'd1,
    S_JUMP   = 2'd2,
    S_FALL   = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic signed [15:0]        xspeed_q, xspeed_d;
  logic signed [15:0]        yspeed_q, yspeed_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [2:0]                btn_prev_q;
  logic [2:0]                pend_q, pend_d;
  logic                      ground_seen_q, ground_seen_d;

  logic [2:0]                w_btn;
  logic                      w_bottom, w_top, w_wall, w_ground_now, w_coll_act;
  logic signed [15:0]        w_y_grav;

  // Button vectors are ordered {right, left, jump}
  assign w_btn        = {right, left, jump};
  assign w_bottom     = collision & HitEdgeCode[0];
  assign w_top        = collision & HitEdgeCode[2];
  assign w_wall       = collision & (HitEdgeCode[3] | HitEdgeCode[1]);
  assign w_ground_now = ground_seen_q | w_bottom;
  assign w_y_grav     = yspeed_q + c_GRAVITY;

  assign pend_d        = startOfFrame ? 3'b000 : (pend_q | (w_btn & ~btn_prev_q));
  assign ground_seen_d = startOfFrame ? 1'b0 : w_ground_now;

  always_comb begin
    state_d    = state_q;
    xspeed_d   = xspeed_q;
    yspeed_d   = yspeed_q;
    cnt_d      = cnt_q;
    w_coll_act = 1'b0;

    // Collision response wins over any frame update in the same clock
    unique case (state_q)
      S_FALL: begin
        if (w_bottom) begin
          state_d = S_GROUND; xspeed_d = '0; yspeed_d = '0; w_coll_act = 1'b1;
        end else if (w_wall) begin
          xspeed_d = '0; w_coll_act = 1'b1;
        end
      end
      S_JUMP: begin
        if (w_bottom && !yspeed_q[15]) begin
          state_d = S_GROUND; xspeed_d = '0; yspeed_d = '0; w_coll_act = 1'b1;
        end else if (w_top) begin
          state_d = S_FALL; yspeed_d = '0; w_coll_act = 1'b1;
        end else if (w_wall) begin
          xspeed_d = '0; w_coll_act = 1'b1;
        end
      end
      S_SIDE: begin
        if (w_wall) begin
          state_d = S_FALL; xspeed_d = '0; yspeed_d = '0; w_coll_act = 1'b1;
        end
      end
      default: ;
    endcase

    if (startOfFrame && !w_coll_act) begin
      unique case (state_q)
        S_GROUND: begin
          if (!w_ground_now) begin
            state_d = S_FALL; yspeed_d = '0;
          end else begin
            case (pend_q)
              3'b100: begin state_d = S_SIDE; xspeed_d = c_SIDE_SPEED;  cnt_d = c_SIDE_FRAMES; end
              3'b010: begin state_d = S_SIDE; xspeed_d = -c_SIDE_SPEED; cnt_d = c_SIDE_FRAMES; end
              3'b001: begin state_d = S_JUMP; yspeed_d = c_JUMP_SPEED; end
              default: ;
            endcase
          end
        end
        S_SIDE: begin
          yspeed_d = '0;
          if (cnt_q == c_CNT_ONE) begin
            state_d = S_FALL; xspeed_d = '0; cnt_d = '0;
          end else begin
            cnt_d = cnt_q - c_CNT_ONE;
          end
        end
        S_JUMP: begin
          yspeed_d = w_y_grav;
          if (!w_y_grav[15]) state_d = S_FALL;
        end
        S_FALL: begin
          yspeed_d = (w_y_grav > c_MAX_FALL) ? c_MAX_FALL : w_y_grav;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= S_GROUND;
      xspeed_q      <= '0;
      yspeed_q      <= '0;
      cnt_q         <= '0;
      btn_prev_q    <= '0;
      pend_q        <= '0;
      ground_seen_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      xspeed_q      <= xspeed_d;
      yspeed_q      <= yspeed_d;
      cnt_q         <= cnt_d;
      btn_prev_q    <= w_btn;
      pend_q        <= pend_d;
      ground_seen_q <= ground_seen_d;
    end
  end

  assign Xspeed   = xspeed_q;
  assign Yspeed   = yspeed_q;
  assign state    = state_q;
  assign onGround = (state_q == S_GROUND);

endmodule
`default_nettype wire
